// File: rtl/attention_row_sequencer.sv
// Row sequencer: issues Q rows into a fixed-latency attention datapath under FIFO credit,
// captures results after DP_LATENCY cycles. Define ATTN_SEQ_PERF_EN to add stall counters.
module attention_row_sequencer #(
    parameter int unsigned S_q        = 4,
    parameter int unsigned DP_LATENCY = 3,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned OUT_DEPTH  = 4,
    parameter int unsigned ROW_W      = (S_q > 1) ? $clog2(S_q) : 1,
    parameter int unsigned CNT_W      = $clog2(S_q + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_job_valid,
    output logic              o_job_ready,
    input  logic [CNT_W-1:0]  i_job_rows,
    output logic              o_dp_issue,
    output logic [ROW_W-1:0]  o_dp_row,
    input  logic [DATA_W-1:0] i_dp_data,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [DATA_W-1:0] o_res_data,
    output logic [ROW_W-1:0]  o_res_row,
    output logic              o_busy,
    output logic              o_done
`ifdef ATTN_SEQ_PERF_EN
    ,
    output logic [31:0]       o_perf_credit_stalls,
    output logic [31:0]       o_perf_out_stalls
`endif
);
    localparam int unsigned PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned FCNT_W = $clog2(OUT_DEPTH + 1);
    localparam int unsigned IFL_W  = $clog2(DP_LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rows_q, rows_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [DP_LATENCY-1:0] pipe_vld_q;
    logic [ROW_W-1:0]   pipe_row_q [DP_LATENCY];
    logic [IFL_W-1:0]   inflight;
    logic [DATA_W-1:0]  mem_data_q [OUT_DEPTH];
    logic [ROW_W-1:0]   mem_row_q [OUT_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic               credit_ok, more_rows, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(DP_LATENCY); i++) begin
            inflight = inflight + IFL_W'(pipe_vld_q[i]);
        end
    end

    // Results already in flight hold a FIFO slot, so a push can never find the FIFO full.
    assign credit_ok = (32'(fifo_cnt_q) + 32'(inflight)) < OUT_DEPTH;
    assign more_rows = issued_q < rows_q;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            rows_q   <= '0;
            issued_q <= '0;
        end else begin
            state_q  <= state_d;
            rows_q   <= rows_d;
            issued_q <= issued_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        rows_d   = rows_q;
        issued_d = issued_q;
        unique case (state_q)
            StIdle: begin
                if (i_job_valid) begin
                    rows_d   = (i_job_rows > CNT_W'(S_q)) ? CNT_W'(S_q) : i_job_rows;
                    issued_d = '0;
                    state_d  = (rows_d == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (o_dp_issue) begin
                    issued_d = issued_q + CNT_W'(1);
                    if (issued_d == rows_q) state_d = StDrain;
                end
            end
            StDrain: begin
                if (inflight == '0 && fifo_cnt_q == '0) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        o_job_ready = (state_q == StIdle);
        o_busy      = (state_q != StIdle);
        o_done      = (state_q == StDone);
        o_dp_issue  = (state_q == StIssue) && more_rows && credit_ok;
        o_dp_row    = o_dp_issue ? ROW_W'(issued_q) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < int'(DP_LATENCY); i++) pipe_row_q[i] <= '0;
        end else begin
            pipe_vld_q[0] <= o_dp_issue;
            pipe_row_q[0] <= o_dp_row;
            for (int i = 1; i < int'(DP_LATENCY); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_row_q[i] <= pipe_row_q[i-1];
            end
        end
    end

    assign push        = pipe_vld_q[DP_LATENCY-1];
    assign o_res_valid = (fifo_cnt_q != '0);
    assign pop         = o_res_valid & i_res_ready;
    assign fifo_cnt_d  = fifo_cnt_q + FCNT_W'(push) - FCNT_W'(pop);
    assign o_res_data  = o_res_valid ? mem_data_q[rd_ptr_q] : '0;
    assign o_res_row   = o_res_valid ? mem_row_q[rd_ptr_q] : '0;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= i_dp_data;
            mem_row_q[wr_ptr_q]  <= pipe_row_q[DP_LATENCY-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

`ifdef ATTN_SEQ_PERF_EN
    logic [31:0] perf_credit_q, perf_out_q;
    logic        job_acc;

    assign job_acc = o_job_ready & i_job_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst || job_acc) begin
            perf_credit_q <= '0;
            perf_out_q    <= '0;
        end else begin
            if (state_q == StIssue && more_rows && !credit_ok && perf_credit_q != '1) begin
                perf_credit_q <= perf_credit_q + 32'd1;
            end
            if (o_res_valid && !i_res_ready && perf_out_q != '1) begin
                perf_out_q <= perf_out_q + 32'd1;
            end
        end
    end

    assign o_perf_credit_stalls = perf_credit_q;
    assign o_perf_out_stalls    = perf_out_q;
`endif

endmodule

// File: tb/tb_attention_row_sequencer.sv
// Self-checking bench for attention_row_sequencer: queue-based reference model compared
// every cycle, plus directed scenarios pinned with hand-computed expectations.
module tb_attention_row_sequencer;
    localparam int S_Q   = 4;
    localparam int DPL   = 3;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int ROW_W = 2;
    localparam int CNT_W = 3;
    localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_DRAIN = 2, PH_DONE = 3;
    localparam logic [DW-1:0] DBASE = 64'hD000_0000_0000_0000;

    logic             clk = 1'b0;
    logic             rst, job_valid, res_ready;
    logic [CNT_W-1:0] job_rows;
    logic [DW-1:0]    dp_data;
    logic             job_ready, dp_issue, res_valid, busy, done;
    logic [ROW_W-1:0] dp_row, res_row;
    logic [DW-1:0]    res_data;

    always #5 clk = ~clk;

    attention_row_sequencer #(
        .S_q(S_Q), .DP_LATENCY(DPL), .DATA_W(DW), .OUT_DEPTH(DEPTH)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_job_valid(job_valid), .o_job_ready(job_ready),
        .i_job_rows(job_rows), .o_dp_issue(dp_issue), .o_dp_row(dp_row),
        .i_dp_data(dp_data), .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_data(res_data), .o_res_row(res_row), .o_busy(busy), .o_done(done)
    );

    typedef struct { logic [DW-1:0] d; int row; } res_t;

    int   n_checks = 0, n_errors = 0, cyc = 0;
    res_t m_fifo[$];
    int   m_rec_cyc[$];
    int   m_rec_row[$];
    int   m_phase, m_rows, m_issued;
    bit   det_data;

    int          n_issue, n_done, n_pop, n_rvalid, first_issue_cyc, last_issue_cyc, done_cyc;
    logic [DW-1:0] first_res;
    logic        s_busy, s_ready, s_rvalid, s_done;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        m_fifo.delete();
        m_rec_cyc.delete();
        m_rec_row.delete();
        m_phase  = PH_IDLE;
        m_rows   = 0;
        m_issued = 0;
    endtask

    task automatic clr_obs();
        n_issue = 0; n_done = 0; n_pop = 0; n_rvalid = 0;
        first_issue_cyc = -1; last_issue_cyc = -1; done_cyc = -1; first_res = '0;
    endtask

    // One clock: compare at the falling edge, then drive inputs and advance the model.
    task automatic step(input bit jv, input int rows, input bit rdy, input bit r);
        bit   e_issue, e_rvalid, push;
        int   infl, fsz;
        res_t ent;
        @(negedge clk);
        infl     = m_rec_cyc.size();
        fsz      = m_fifo.size();
        e_issue  = (m_phase == PH_ISSUE) && (m_issued < m_rows) && (fsz + infl < DEPTH);
        e_rvalid = (fsz > 0);
        chk("job_ready", job_ready, m_phase == PH_IDLE);
        chk("busy", busy, m_phase != PH_IDLE);
        chk("done", done, m_phase == PH_DONE);
        chk("dp_issue", dp_issue, e_issue);
        if (e_issue) chk("dp_row", dp_row, m_issued);
        chk("res_valid", res_valid, e_rvalid);
        if (e_rvalid) begin
            chk("res_data", res_data, m_fifo[0].d);
            chk("res_row", res_row, m_fifo[0].row);
        end

        if (dp_issue) begin
            if (n_issue == 0) first_issue_cyc = cyc;
            last_issue_cyc = cyc;
            n_issue++;
        end
        if (done) begin
            if (n_done == 0) done_cyc = cyc;
            n_done++;
        end
        if (res_valid) begin
            if (n_rvalid == 0) first_res = res_data;
            n_rvalid++;
            if (rdy) n_pop++;
        end
        s_busy = busy; s_ready = job_ready; s_rvalid = res_valid; s_done = done;

        rst       = r;
        job_valid = jv;
        job_rows  = CNT_W'(rows);
        res_ready = rdy;
        dp_data   = det_data ? (DBASE + 64'(cyc)) : {$urandom, $urandom};

        if (r) begin
            model_clear();
        end else begin
            push = (infl > 0) && (m_rec_cyc[0] == cyc - DPL);
            if (e_rvalid && rdy) void'(m_fifo.pop_front());
            if (push) begin
                chk("no_overflow", m_fifo.size() < DEPTH, 1'b1);
                ent.d   = dp_data;
                ent.row = m_rec_row[0];
                m_fifo.push_back(ent);
                void'(m_rec_cyc.pop_front());
                void'(m_rec_row.pop_front());
            end
            if (e_issue) begin
                m_rec_cyc.push_back(cyc);
                m_rec_row.push_back(m_issued);
            end
            case (m_phase)
                PH_IDLE: if (jv) begin
                    m_rows   = (rows > S_Q) ? S_Q : rows;
                    m_issued = 0;
                    m_phase  = (m_rows == 0) ? PH_DONE : PH_ISSUE;
                end
                PH_ISSUE: if (e_issue) begin
                    m_issued++;
                    if (m_issued == m_rows) m_phase = PH_DRAIN;
                end
                PH_DRAIN: if (infl == 0 && fsz == 0) m_phase = PH_DONE;
                PH_DONE:  m_phase = PH_IDLE;
                default:  m_phase = PH_IDLE;
            endcase
        end
        cyc++;
    endtask

    task automatic run(input int n, input bit jv, input int rows, input bit rdy);
        for (int i = 0; i < n; i++) step(jv, rows, rdy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        rst = 1'b1; job_valid = 1'b0; job_rows = '0; res_ready = 1'b0; dp_data = '0;
        det_data = 1'b1;
        model_clear();
        clr_obs();
        repeat (3) @(posedge clk);

        // Reset state
        step(1'b0, 0, 1'b1, 1'b0);
        chk("rst_job_ready", s_ready, 1'b1);
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_res_valid", s_rvalid, 1'b0);
        chk("rst_done", s_done, 1'b0);
        chk("rst_dp_row", dp_row, '0);
        chk("rst_res_data", res_data, '0);
        chk("rst_res_row", res_row, '0);

        // Full-rate job, 4 rows, no backpressure
        clr_obs(); a = cyc;
        step(1'b1, 4, 1'b1, 1'b0);
        run(12, 1'b0, 0, 1'b1);
        chk("t1_issue_count", n_issue, 4);
        chk("t1_first_issue_lat", first_issue_cyc - a, 1);
        chk("t1_issue_span", last_issue_cyc - first_issue_cyc, 3);
        chk("t1_first_result", first_res, DBASE + 64'(first_issue_cyc + DPL));
        chk("t1_pops", n_pop, 4);
        chk("t1_done_count", n_done, 1);
        chk("t1_done_lat", done_cyc - a, 10);
        chk("t1_ready_after", s_ready, 1'b1);

        // Output stalled: FIFO fills, then drains in order
        clr_obs();
        step(1'b1, 4, 1'b0, 1'b0);
        run(8, 1'b0, 0, 1'b0);
        chk("t2_issue_count", n_issue, 4);
        chk("t2_no_pop", n_pop, 0);
        chk("t2_held", s_rvalid, 1'b1);
        clr_obs();
        run(12, 1'b0, 0, 1'b1);
        chk("t2_pops", n_pop, 4);
        chk("t2_done_count", n_done, 1);

        // Zero-row job
        clr_obs();
        step(1'b1, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("t3_done_next", s_done, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("t3_ready_again", s_ready, 1'b1);
        chk("t3_no_issue", n_issue, 0);
        chk("t3_done_count", n_done, 1);

        // Oversized job is clamped
        clr_obs();
        step(1'b1, 7, 1'b1, 1'b0);
        run(14, 1'b0, 0, 1'b1);
        chk("t4_issue_count", n_issue, 4);
        chk("t4_done_count", n_done, 1);

        // Reset mid-job, one cycle after the second issue
        clr_obs();
        step(1'b1, 4, 1'b1, 1'b0);
        for (int k = 0; k < 10 && n_issue < 2; k++) step(1'b0, 0, 1'b1, 1'b0);
        chk("t5_two_issues", n_issue, 2);
        step(1'b0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("t5_busy", s_busy, 1'b0);
        chk("t5_res_valid", s_rvalid, 1'b0);
        chk("t5_job_ready", s_ready, 1'b1);
        clr_obs();
        run(10, 1'b0, 0, 1'b1);
        chk("t5_no_done", n_done, 0);
        chk("t5_no_results", n_rvalid, 0);

        // Ready toggling every cycle
        clr_obs();
        step(1'b1, 4, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 0, (i % 2) == 1, 1'b0);
        chk("t6_pops", n_pop, 4);
        chk("t6_done_count", n_done, 1);

        // Randomized traffic
        det_data = 1'b0;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
        end
        run(20, 1'b0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
